// File: rtl/word_demux_pkg.sv
// -----------------------------------------------------------------------------
// word_demux_pkg
//
// Purpose : Shared types and constants for the 1-to-2 word demultiplexer
//           (word_demux_1to2) and its per-channel buffer (demux_chan_buf).
//
// Contents:
//   WIDTH_DEFAULT   default data word width
//   NUM_CH          number of output channels
//   chan_sel_t      per-word channel select (1 bit)
//   chan_occ_t      per-channel occupancy count (0..2)
//   CH0, CH1        channel select / index values
//   chan_state_e    per-channel buffer state; encoding equals occupancy
//
// Optional feature macro used by the files importing this package:
//   DEMUX_PARITY_EN  adds even-parity outputs per channel
// -----------------------------------------------------------------------------
package word_demux_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int NUM_CH        = 2;

   typedef logic       chan_sel_t;
   typedef logic [1:0] chan_occ_t;

   localparam chan_sel_t CH0 = 1'b0;
   localparam chan_sel_t CH1 = 1'b1;

   // The state encoding is chosen so that the state value is the occupancy,
   // which lets the buffer derive its count with a plain cast.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } chan_state_e;

endpackage : word_demux_pkg

// File: rtl/demux_chan_buf.sv
// -----------------------------------------------------------------------------
// demux_chan_buf
//
// Purpose : One output channel of the demultiplexer. A 2-entry FIFO whose head
//           entry is itself the output register, so data_o and valid_o come
//           straight from flops. A word pushed into an empty channel is visible
//           on the very next cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; empties the buffer, clears head
//   push_i   in   write data_i this cycle (caller only pushes when !full_o,
//                 or when a pop frees a slot in the same cycle)
//   data_i   in   word to store
//   ready_i  in   consumer accepts the head word
//   data_o   out  head word (registered)
//   valid_o  out  head word valid (registered state decode)
//   full_o   out  occupancy is 2
//   par_o    out  even parity of the head word (DEMUX_PARITY_EN only)
//
// Configuration macro: DEMUX_PARITY_EN
// -----------------------------------------------------------------------------
module demux_chan_buf
   import word_demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o
`ifdef DEMUX_PARITY_EN
   ,
   output logic             par_o
`endif
);

   // Each stored entry optionally carries its parity bit in the MSB, so the
   // parity moves through the FIFO with exactly the same control as the data.
`ifdef DEMUX_PARITY_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif

   chan_state_e   state_q, state_d;
   logic [EW-1:0] head_q, head_d;
   logic [EW-1:0] tail_q, tail_d;
   logic [EW-1:0] entry_in;
   chan_occ_t     occ;
   logic          pop;
   logic          push_ok;

`ifdef DEMUX_PARITY_EN
   assign entry_in = {^data_i, data_i};
`else
   assign entry_in = data_i;
`endif

   assign occ     = chan_occ_t'(state_q);
   assign valid_o = (occ != 2'd0);
   assign full_o  = (occ == 2'd2);
   assign pop     = valid_o && ready_i;
   // A push into a full channel is only meaningful if the head leaves in the
   // same cycle; otherwise it is dropped rather than overwriting the tail.
   assign push_ok = push_i && (!full_o || pop);

   assign data_o = head_q[WIDTH-1:0];
`ifdef DEMUX_PARITY_EN
   assign par_o  = head_q[WIDTH];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         ST_EMPTY: begin
            // Nothing to pop; a push lands directly in the output register.
            if (push_ok) begin
               head_d  = entry_in;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({push_ok, pop})
               2'b10: begin
                  tail_d  = entry_in;
                  state_d = ST_FULL;
               end
               2'b01: begin
                  state_d = ST_EMPTY;
               end
               2'b11: begin
                  // Head leaves and the new word replaces it; count stays 1.
                  head_d = entry_in;
               end
               default: begin
               end
            endcase
         end
         ST_FULL: begin
            if (pop) begin
               head_d = tail_q;
               if (push_ok) begin
                  tail_d = entry_in;
               end else begin
                  state_d = ST_ONE;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

endmodule : demux_chan_buf

// File: rtl/word_demux_1to2.sv
// -----------------------------------------------------------------------------
// word_demux_1to2
//
// Purpose : Registered 1-to-2 word demultiplexer on the result return path.
//           Each accepted word is steered by in_sel into one of two
//           independent 2-entry channel buffers. A stalled consumer only
//           back-pressures words addressed to its own channel.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high; discards all buffered words
//   in_data     in   word to route
//   in_sel      in   0 -> channel 0, 1 -> channel 1 (sampled on accept only)
//   in_valid    in   in_data / in_sel valid
//   in_ready    out  !full of the selected channel; independent of out*_ready
//   out0_data   out  channel 0 head word (registered)
//   out0_valid  out  channel 0 head valid (registered)
//   out0_ready  in   channel 0 consumer accepts head
//   out1_*      same as out0_*, for channel 1
//   out0_par,
//   out1_par    out  even parity of head word (DEMUX_PARITY_EN only)
//
// Configuration macro: DEMUX_PARITY_EN
// -----------------------------------------------------------------------------
module word_demux_1to2
   import word_demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef DEMUX_PARITY_EN
   ,
   output logic             out0_par,
   output logic             out1_par
`endif
);

   logic [NUM_CH-1:0] ch_full;
   logic [NUM_CH-1:0] ch_push;
   logic [NUM_CH-1:0] ch_ready;
   logic [NUM_CH-1:0] ch_valid;
   logic [WIDTH-1:0]  ch_data [NUM_CH];
`ifdef DEMUX_PARITY_EN
   logic [NUM_CH-1:0] ch_par;
`endif
   logic              accept;
   chan_sel_t         sel;

   assign sel = in_sel;

   // Readiness looks only at the registered fill level of the addressed
   // channel; consumer ready is deliberately excluded to keep this path short
   // and free of any combinational loop through the consumers.
   assign in_ready = !ch_full[sel];
   assign accept   = in_valid && in_ready;

   assign ch_ready[CH0] = out0_ready;
   assign ch_ready[CH1] = out1_ready;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
         assign ch_push[gi] = accept && (sel == chan_sel_t'(gi));

         demux_chan_buf #(
            .WIDTH (WIDTH)
         ) u_buf (
            .clk     (clk),
            .reset   (reset),
            .push_i  (ch_push[gi]),
            .data_i  (in_data),
            .ready_i (ch_ready[gi]),
            .data_o  (ch_data[gi]),
            .valid_o (ch_valid[gi]),
            .full_o  (ch_full[gi])
`ifdef DEMUX_PARITY_EN
            ,
            .par_o   (ch_par[gi])
`endif
         );
      end
   endgenerate

   assign out0_data  = ch_data[CH0];
   assign out0_valid = ch_valid[CH0];
   assign out1_data  = ch_data[CH1];
   assign out1_valid = ch_valid[CH1];
`ifdef DEMUX_PARITY_EN
   assign out0_par   = ch_par[CH0];
   assign out1_par   = ch_par[CH1];
`endif

endmodule : word_demux_1to2
